// File: rtl/register_file_16x32_if.sv
// Bus interface for register_file_16x32.
// Carries the write port, the PC increment strobe, both read ports and the
// registered status outputs. Clock and reset are plain ports of the module.
//   master : drives write_en/write_sel/write_data/pc_inc_en/read_sel_a/read_sel_b,
//            observes read_data_a/read_data_b/pc_out/write_done/write_count
//   slave  : the register file itself (direction mirrored)
interface register_file_16x32_if;
   logic        write_en;
   logic [3:0]  write_sel;
   logic [31:0] write_data;
   logic        pc_inc_en;
   logic [3:0]  read_sel_a;
   logic [3:0]  read_sel_b;
   logic [31:0] read_data_a;
   logic [31:0] read_data_b;
   logic [31:0] pc_out;
   logic        write_done;
   logic [7:0]  write_count;

   modport master (
      output write_en, write_sel, write_data, pc_inc_en, read_sel_a, read_sel_b,
      input  read_data_a, read_data_b, pc_out, write_done, write_count
   );

   modport slave (
      input  write_en, write_sel, write_data, pc_inc_en, read_sel_a, read_sel_b,
      output read_data_a, read_data_b, pc_out, write_done, write_count
   );
endinterface

// File: rtl/register_file_16x32.sv
// 16 x 32-bit register file, r15 doubling as the program counter.
// Ports:
//   clk   - single clock, all state updates on the rising edge
//   reset - asynchronous active-high reset (r0..r14 = 0, r15 = PC_RESET)
//   bus   - register_file_16x32_if.slave: one write port, two combinational
//           read ports with write-through bypass, PC increment strobe,
//           pc_out, write_done pulse and an 8-bit wrapping write counter.
// Parameters:
//   PC_RESET - value of r15 after reset
//   PC_STEP  - amount added to r15 when pc_inc_en is high
module register_file_16x32 #(
   parameter logic [31:0] PC_RESET = 32'd0,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic                 clk,
   input  logic                 reset,
   register_file_16x32_if.slave bus
);

   logic [31:0] regs [16];
   logic [15:0] write_hit;
   logic        write_done_q;
   logic [7:0]  write_count_q;
   logic        bypass_en;

   // One-hot write decode; gated by write_en so an undefined write_sel
   // cannot select anything while the port is idle.
   always_comb begin
      write_hit = '0;
      if (bus.write_en) begin
         write_hit = 16'd1 << bus.write_sel;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < 15; i++) begin
            regs[i] <= '0;
         end
         regs[15]      <= PC_RESET;
         write_done_q  <= 1'b0;
         write_count_q <= '0;
      end else begin
         for (int unsigned i = 0; i < 15; i++) begin
            if (write_hit[i]) begin
               regs[i] <= bus.write_data;
            end
         end
         // An explicit write to r15 takes priority over the increment.
         if (write_hit[15]) begin
            regs[15] <= bus.write_data;
         end else if (bus.pc_inc_en) begin
            regs[15] <= regs[15] + PC_STEP;
         end
         write_done_q <= bus.write_en;
         if (bus.write_en) begin
            write_count_q <= write_count_q + 8'd1;
         end
      end
   end

   // Write-through bypass is suppressed during reset so reads show the
   // reset contents rather than the ignored write data.
   assign bypass_en = bus.write_en && !reset;

   assign bus.read_data_a = (bypass_en && (bus.write_sel == bus.read_sel_a))
                            ? bus.write_data : regs[bus.read_sel_a];
   assign bus.read_data_b = (bypass_en && (bus.write_sel == bus.read_sel_b))
                            ? bus.write_data : regs[bus.read_sel_b];

   assign bus.pc_out      = regs[15];
   assign bus.write_done  = write_done_q;
   assign bus.write_count = write_count_q;

endmodule

// File: tb/tb_register_file_16x32.sv
// Self-checking bench for register_file_16x32: directed steps followed by
// randomized traffic, all compared against an array-based reference model.
module tb_register_file_16x32;
   localparam logic [31:0] PC_RESET = 32'd0;
   localparam logic [31:0] PC_STEP  = 32'd4;

   logic clk = 1'b0;
   logic reset;

   register_file_16x32_if bus();

   register_file_16x32 #(
      .PC_RESET(PC_RESET),
      .PC_STEP (PC_STEP)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   // Reference model state
   logic [31:0] mem [16];
   logic [7:0]  cnt_m;
   logic        done_m;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 15; i++) mem[i] = 32'd0;
      mem[15] = PC_RESET;
      cnt_m   = 8'd0;
      done_m  = 1'b0;
   endtask

   // Effect of one rising edge on the architectural state.
   task automatic model_edge();
      if (reset) return;
      if (bus.write_en === 1'b1) begin
         mem[bus.write_sel] = bus.write_data;
         cnt_m = cnt_m + 8'd1;
      end
      if (!(bus.write_en === 1'b1 && bus.write_sel == 4'd15) && bus.pc_inc_en === 1'b1)
         mem[15] = mem[15] + PC_STEP;
      done_m = (bus.write_en === 1'b1);
   endtask

   function automatic logic [31:0] exp_read(input logic [3:0] sel);
      if (!reset && bus.write_en === 1'b1 && bus.write_sel === sel) return bus.write_data;
      return mem[sel];
   endfunction

   task automatic drive(input logic we, input logic [3:0] ws, input logic [31:0] wd,
                        input logic inc, input logic [3:0] ra, input logic [3:0] rb);
      bus.write_en   = we;
      bus.write_sel  = ws;
      bus.write_data = wd;
      bus.pc_inc_en  = inc;
      bus.read_sel_a = ra;
      bus.read_sel_b = rb;
   endtask

   task automatic check_reads(input string tag);
      #1;
      chk({tag, "_rda"}, bus.read_data_a, exp_read(bus.read_sel_a));
      chk({tag, "_rdb"}, bus.read_data_b, exp_read(bus.read_sel_b));
   endtask

   task automatic check_regs(input string tag);
      chk({tag, "_pc"},    bus.pc_out, mem[15]);
      chk({tag, "_done"},  {31'd0, bus.write_done}, {31'd0, done_m});
      chk({tag, "_count"}, {24'd0, bus.write_count}, {24'd0, cnt_m});
   endtask

   // Advance one edge, update the model, sample 1 time unit later.
   task automatic tick(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_regs(tag);
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0);
      model_reset();
      @(posedge clk); #1;

      // Reset contents on both ports
      for (int i = 0; i < 16; i++) begin
         bus.read_sel_a = 4'(i);
         bus.read_sel_b = 4'(15 - i);
         check_reads("rst_read");
      end
      chk("rst_r15", bus.read_data_a, PC_RESET);
      check_regs("rst");
      @(posedge clk); #1;
      reset = 1'b0;

      // PC increments from reset: 0 -> 4 -> 8 -> 12
      chk("pc0", bus.pc_out, 32'd0);
      drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd15, 4'd15);
      tick("inc1"); chk("pc4", bus.pc_out, 32'd4);
      tick("inc2"); chk("pc8", bus.pc_out, 32'd8);
      check_reads("inc_read");
      tick("inc3"); chk("pc12", bus.pc_out, 32'd12);

      // Write r3 then read it back on both ports
      drive(1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 4'd0, 4'd1);
      tick("w3");
      drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd3, 4'd3);
      check_reads("r3");
      chk("r3_const", bus.read_data_a, 32'hDEADBEEF);
      chk("w3_done", {31'd0, bus.write_done}, 32'd1);
      chk("w3_count", {24'd0, bus.write_count}, 32'd1);
      tick("idle");
      chk("done_drop", {31'd0, bus.write_done}, 32'd0);

      // Same-cycle bypass on r7
      drive(1'b1, 4'd7, 32'h12345678, 1'b0, 4'd7, 4'd3);
      check_reads("byp7");
      chk("byp7_const", bus.read_data_a, 32'h12345678);
      tick("w7");

      // Write to r15 beats increment, bypass on r15
      drive(1'b1, 4'd15, 32'h100, 1'b1, 4'd15, 4'd7);
      check_reads("byp15");
      tick("w15");
      chk("w15_wins", bus.pc_out, 32'h100);

      // PC wrap
      drive(1'b1, 4'd15, 32'hFFFFFFFC, 1'b0, 4'd15, 4'd0);
      tick("w15b");
      drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd15, 4'd0);
      check_reads("pre_wrap");
      tick("wrap");
      chk("wrap_zero", bus.pc_out, 32'd0);

      // Randomized traffic, occasional undefined write_sel while idle
      for (int n = 0; n < 300; n++) begin
         drive(1'($urandom_range(0, 1)), 4'($urandom), $urandom, 1'($urandom_range(0, 1)),
               4'($urandom), 4'($urandom));
         if (bus.write_en == 1'b0 && $urandom_range(0, 3) == 0) bus.write_sel = 'x;
         if ($urandom_range(0, 3) == 0) bus.read_sel_a = bus.write_sel;
         check_reads("rnd");
         tick("rnd");
      end

      // Fill r1..r15, then assert reset mid-cycle during a write
      for (int i = 1; i < 16; i++) begin
         drive(1'b1, 4'(i), 32'hA5000000 | 32'(i), 1'b0, 4'(i), 4'(i));
         tick("fill");
      end
      drive(1'b1, 4'd5, 32'hCAFEF00D, 1'b1, 4'd5, 4'd15);
      #3;
      reset = 1'b1;
      model_reset();
      #1;
      chk("arst_rda", bus.read_data_a, 32'd0);
      chk("arst_rdb", bus.read_data_b, PC_RESET);
      check_regs("arst");
      for (int i = 0; i < 16; i++) begin
         bus.read_sel_a = 4'(i);
         bus.read_sel_b = 4'(i);
         check_reads("arst_all");
      end
      // Writes and increments ignored while held in reset
      bus.read_sel_a = 4'd5;
      tick("hold");
      check_reads("hold");
      #2;
      reset = 1'b0;
      drive(1'b1, 4'd9, 32'h0BADC0DE, 1'b0, 4'd9, 4'd5);
      check_reads("post_rst");
      tick("post_rst");
      chk("post_rst_cnt", {24'd0, bus.write_count}, 32'd1);

      // 256 writes bring the counter back to the same value
      for (int i = 0; i < 256; i++) begin
         drive(1'b1, 4'($urandom), $urandom, 1'b0, 4'($urandom), 4'($urandom));
         @(posedge clk);
         model_edge();
         #1;
      end
      check_regs("wrap_cnt");
      chk("wrap_cnt_const", {24'd0, bus.write_count}, 32'd1);
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 4'd0, 32'd0, 1'b0, 4'(i), 4'(15 - i));
         check_reads("final");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog observed timeout expected finish");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/register_file_16x32.md
REGISTER_FILE_16X32 -- requirements
Module: register_file_16x32

Interface
REQ-001 Parameter PC_RESET, default 32'd0, value loaded into r15 (program counter) on reset.
REQ-002 Parameter PC_STEP, default 32'd4, amount added to r15 per increment.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 write_en  input  1  write-port enable.
REQ-006 write_sel  input  4  destination register index 0..15.
REQ-007 write_data  input  32  data to write.
REQ-008 pc_inc_en  input  1  r15 increments by PC_STEP this cycle.
REQ-009 read_sel_a  input  4  read port A index.
REQ-010 read_sel_b  input  4  read port B index.
REQ-011 read_data_a  output  32  port A data, combinational.
REQ-012 read_data_b  output  32  port B data, combinational.
REQ-013 pc_out  output  32  current r15 contents, registered value.
REQ-014 write_done  output  1  registered one-cycle pulse acknowledging an accepted write.
REQ-015 write_count  output  8  registered count of accepted writes.

Function
REQ-016 Storage SHALL be 16 registers of 32 bits, r0..r15; r15 is the program counter; r0 is general purpose (not hardwired zero).
REQ-017 Write port SHALL decode write_sel 4-to-16; with write_en=1 exactly one register loads write_data at the rising edge; write_en=0 leaves all r0..r14 unchanged.
REQ-018 r15 update priority per edge: write_en=1 and write_sel=15 -> load write_data; else pc_inc_en=1 -> r15 + PC_STEP; else hold.
REQ-019 PC increment SHALL wrap modulo 2^32 (32'hFFFFFFFC + 4 -> 32'h00000000); no overflow flag.
REQ-020 Read ports SHALL be purely combinational from read_sel and stored contents, each an independent 16-to-1 selection; both ports may address the same register.
REQ-021 Write bypass: when write_en=1 and write_sel equals read_sel_x, read_data_x SHALL present write_data in the same cycle (write-through), for all indices including 15.
REQ-022 When r15 is read without bypass, read_data_x SHALL equal pc_out (pre-increment value of the current cycle).
REQ-023 Read latency 0 cycles; write-to-read latency 0 cycles via bypass, 1 cycle via storage.
REQ-024 write_done SHALL be 1 for exactly the cycle after each edge at which write_en=1, else 0; back-to-back writes hold it high continuously.
REQ-025 write_count SHALL increment by 1 per accepted write, wrapping 8'hFF -> 8'h00.
REQ-026 Inputs X/undefined on write_sel with write_en=0 SHALL not alter state.

Reset
REQ-027 reset=1 SHALL immediately, without waiting for clk, set r0..r14 = 0, r15 = PC_RESET, write_done = 0, write_count = 0.
REQ-028 While reset=1, writes and increments SHALL be ignored; read_data_x reflects reset contents (bypass disabled).
REQ-029 Reset asserted mid-cycle during a write SHALL discard that write; first edge after deassertion operates normally.

Verification
REQ-030 Reset then read all 16 indices on both ports -> 0 for r0..r14, PC_RESET for r15; pc_out=PC_RESET; write_count=0.
REQ-031 Write r3=32'hDEADBEEF, next cycle read_sel_a=3, read_sel_b=3 -> both 32'hDEADBEEF; write_done=1 one cycle; write_count=1.
REQ-032 Same-cycle write r7=32'h12345678 with read_sel_a=7 -> read_data_a=32'h12345678 before the edge (bypass).
REQ-033 pc_inc_en=1 for 3 cycles from reset -> pc_out 0,4,8,12; load r15=32'hFFFFFFFC then one increment -> 32'h00000000.
REQ-034 write_en=1, write_sel=15, write_data=32'h100 with pc_inc_en=1 -> pc_out=32'h100 (write wins).
REQ-035 Assert reset asynchronously between edges after writes to r1..r15 -> all state returns to reset values before next edge; 256 writes -> write_count wraps to 0.
